// File: rtl/next_pc_pkg.sv
// Shared encodings and field positions for the next-PC unit.
// NEXT_PC_RAS_EN (defined externally) selects whether the return-address stack is built.
package next_pc_pkg;
    localparam logic [2:0] OP_NEXT   = 3'd0;
    localparam logic [2:0] OP_BRANCH = 3'd1;
    localparam logic [2:0] OP_JUMP   = 3'd2;
    localparam logic [2:0] OP_JAL    = 3'd3;
    localparam logic [2:0] OP_JR     = 3'd4;

    localparam int DEF_ADDR_W    = 32;
    localparam int DEF_JIDX_W    = 26;
    localparam int DEF_RAS_DEPTH = 4;

    localparam int INSTR_W = 32;
    localparam int IMM_W   = 16;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;
endpackage

// File: rtl/return_addr_stack.sv
// Circular return-address stack: JAL pushes overwrite the oldest entry when full,
// JR pops compare the top entry with the real target and flag a mismatch next cycle.
module return_addr_stack #(
    parameter int ADDR_W    = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               i_push,
    input  logic                               i_pop,
    input  logic [ADDR_W-1:0]                  i_push_data,
    input  logic [ADDR_W-1:0]                  i_cmp_value,
    output logic [$clog2(RAS_DEPTH+1)-1:0]     o_count,
    output logic                               o_mismatch
);
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(RAS_DEPTH);

    logic [ADDR_W-1:0] r_stack [RAS_DEPTH];
    logic [PTR_W-1:0]  r_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_mismatch;
    logic [PTR_W-1:0]  w_top_ptr;
    logic              w_pop_ok;

    // r_ptr is the next free slot; the top entry sits one below it (mod depth).
    assign w_top_ptr = r_ptr - PTR_W'(1);
    assign w_pop_ok  = i_pop && (r_count != '0);

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_stack[r_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr      <= '0;
            r_count    <= '0;
            r_mismatch <= 1'b0;
        end else begin
            r_mismatch <= w_pop_ok && (r_stack[w_top_ptr] != i_cmp_value);
            if (i_push) begin
                r_ptr <= r_ptr + PTR_W'(1);
                if (r_count != FULL) begin
                    r_count <= r_count + CNT_W'(1);
                end
            end else if (w_pop_ok) begin
                r_ptr   <= w_top_ptr;
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    assign o_count    = r_count;
    assign o_mismatch = r_mismatch;
endmodule

// File: rtl/next_pc_unit.sv
// PC register and next-address generator (sequential, branch, J/JAL, JR) with JAL link output.
// Return-address stack is built only when NEXT_PC_RAS_EN is defined.
module next_pc_unit
    import next_pc_pkg::*;
#(
    parameter int                ADDR_W    = DEF_ADDR_W,
    parameter int                JIDX_W    = DEF_JIDX_W,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int                RAS_DEPTH = DEF_RAS_DEPTH
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               stall,
    input  logic [2:0]                         op,
    input  logic [INSTR_W-1:0]                 instr,
    input  logic [ADDR_W-1:0]                  rs_value,
    input  logic                               branch_taken,
    output logic [ADDR_W-1:0]                  pc,
    output logic [ADDR_W-1:0]                  pc_plus4,
    output logic [ADDR_W-1:0]                  link_addr,
    output logic                               link_valid,
    output logic                               ras_mispredict,
    output logic [$clog2(RAS_DEPTH+1)-1:0]     ras_count
);
    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_link_addr;
    logic              r_link_valid;
    logic [ADDR_W-1:0] w_pc_plus4;
    logic [ADDR_W-1:0] w_branch_tgt;
    logic [ADDR_W-1:0] w_jump_tgt;
    logic [ADDR_W-1:0] w_next_pc;
    logic              w_accept_jal;
    logic              w_accept_jr;
    logic              w_unused_instr;

    function automatic logic [ADDR_W-1:0] branch_offset(input logic [IMM_W-1:0] imm);
        logic signed [ADDR_W-1:0] ext;
        ext = ADDR_W'(signed'(imm));
        return ext <<< 2;
    endfunction

    assign w_unused_instr = &{1'b0, instr[INSTR_W-1:JIDX_W]};

    assign w_pc_plus4   = r_pc + PC_STEP;
    assign w_branch_tgt = w_pc_plus4 + branch_offset(instr[IMM_MSB:IMM_LSB]);
    assign w_jump_tgt   = {w_pc_plus4[ADDR_W-1:JIDX_W+2], instr[JIDX_W-1:0], 2'b00};
    assign w_accept_jal = !stall && (op == OP_JAL);
    assign w_accept_jr  = !stall && (op == OP_JR);

    always_comb begin
        w_next_pc = w_pc_plus4;
        case (op)
            OP_BRANCH:      w_next_pc = branch_taken ? w_branch_tgt : w_pc_plus4;
            OP_JUMP,
            OP_JAL:         w_next_pc = w_jump_tgt;
            OP_JR:          w_next_pc = rs_value;
            default:        w_next_pc = w_pc_plus4;
        endcase
    end

    // fetch stage boundary: PC and link registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc         <= RESET_PC;
            r_link_addr  <= '0;
            r_link_valid <= 1'b0;
        end else begin
            r_link_valid <= w_accept_jal;
            if (!stall) begin
                r_pc <= w_next_pc;
            end
            if (w_accept_jal) begin
                r_link_addr <= w_pc_plus4;
            end
        end
    end

    assign pc         = r_pc;
    assign pc_plus4   = w_pc_plus4;
    assign link_addr  = r_link_addr;
    assign link_valid = r_link_valid;

`ifdef NEXT_PC_RAS_EN
    return_addr_stack #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_accept_jal),
        .i_pop       (w_accept_jr),
        .i_push_data (w_pc_plus4),
        .i_cmp_value (rs_value),
        .o_count     (ras_count),
        .o_mismatch  (ras_mispredict)
    );
`else
    logic w_unused_ras;
    assign w_unused_ras   = w_accept_jr;
    assign ras_count      = '0;
    assign ras_mispredict = 1'b0;
`endif
endmodule
